multi_ctrl_fwd_arb: RTL and testbench

//  Round-robin arbiter that shares one multicast forward-pipe stage among NUM_REQ requesters.

---
 rtl/multi_ctrl_fwd_arb.sv | 193 +++++++++++++++++++
 tb/tb_multi_ctrl_fwd_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ctrl_fwd_arb.sv
// multi_ctrl_fwd_arb: round-robin arbiter feeding one registered multicast
// forward slot. A beat is held until every addressed destination takes it;
// destinations retire independently. The winning requester is acked in the
// same cycle the slot frees up, so back-to-back beats flow without bubbles.
//
// Optional build macro MCFP_ARB_LOCK_EN: adds req_last_i and keeps the grant
// on one requester until its end-of-packet beat is accepted.
`timescale 1ns/1ps

// One pending bit of the output slot, one instance per destination.
module multi_ctrl_fwd_arb_dst (
  input  logic clk,
  input  logic rst_n,
  input  logic acc_i,
  input  logic dest_i,
  input  logic ready_i,
  output logic pend_o,
  output logic blk_o
);
  logic pend_q, pend_d;

  // A new beat loads its dest bit; otherwise the bit clears once taken.
  always_comb begin
    pend_d = pend_q & ~ready_i;
    if (acc_i) pend_d = dest_i;
  end

  // Pending bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end

  assign pend_o = pend_q;
  // Still owed to this destination after the current cycle.
  assign blk_o  = pend_q & ~ready_i;
endmodule

module multi_ctrl_fwd_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 256,
  parameter int DEST_N  = 2,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DEST_N-1:0] req_dest_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
`ifdef MCFP_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_last_i,
`endif
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [DEST_N-1:0]         b_valid_out,
  output logic [DATA_W-1:0]         b_data_out,
  input  logic [DEST_N-1:0]         b_ready_in,
  output logic [ID_W-1:0]           grant_id_o,
  output logic                      busy_o
);
  // Per-requester views of the flat buses; element i sits at [i*W +: W].
  logic [NUM_REQ-1:0][DEST_N-1:0] dest_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_a;
  assign dest_a = req_dest_i;
  assign data_a = req_data_i;

  logic [DEST_N-1:0]  pend, blk;
  logic               slot_free;
  logic [NUM_REQ-1:0] cand;
  logic               found, accept;
  logic [ID_W-1:0]    win, win_inc, idx;
  logic [DEST_N-1:0]  win_dest;

  logic [DATA_W-1:0]  data_q, data_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  // Output slot: one pending bit per destination.
  for (genvar d = 0; d < DEST_N; d++) begin : g_dst
    multi_ctrl_fwd_arb_dst u_dst (
      .clk     (clk),
      .rst_n   (rst_n),
      .acc_i   (accept),
      .dest_i  (win_dest[d]),
      .ready_i (b_ready_in[d]),
      .pend_o  (pend[d]),
      .blk_o   (blk[d])
    );
  end

  // Free when nothing stays owed past this cycle (empty or last bits retiring).
  assign slot_free = ~|blk;

`ifdef MCFP_ARB_LOCK_EN
  logic            lock_q, lock_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;

  // While locked only the packet owner may compete.
  always_comb begin
    cand = req_valid_i;
    if (lock_q) cand = req_valid_i & (NUM_REQ'(1) << lock_id_q);
  end
`else
  // Per-beat arbitration: every valid requester competes.
  always_comb begin
    cand = req_valid_i;
  end
`endif

  // Round-robin search: first candidate at or after the pointer, wrapping.
  // Walking downward lets the nearest candidate overwrite farther ones.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign accept   = slot_free & found;
  assign win_dest = accept ? dest_a[win] : '0;
  assign win_inc  = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;

  // Same-cycle one-hot ack to the winner.
  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o = NUM_REQ'(1) << win;
  end

  // Payload and owner update only for beats that actually go somewhere;
  // a zero-mask beat is consumed but leaves the previous contents in place.
  always_comb begin
    data_d = data_q;
    gid_d  = gid_q;
    if (accept && (|dest_a[win])) begin
      data_d = data_a[win];
      gid_d  = win;
    end
  end

`ifdef MCFP_ARB_LOCK_EN
  // Pointer moves only when a packet ends; a non-last beat takes the lock.
  always_comb begin
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      lock_d    = ~req_last_i[win];
      lock_id_d = win;
      if (req_last_i[win]) ptr_d = win_inc;
    end
  end

  // Lock state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`else
  // Pointer steps past every accepted beat, including dropped ones.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = win_inc;
  end
`endif

  // Payload, owner id and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      gid_q  <= '0;
      ptr_q  <= '0;
    end else begin
      data_q <= data_d;
      gid_q  <= gid_d;
      ptr_q  <= ptr_d;
    end
  end

  assign b_valid_out = pend;
  assign b_data_out  = data_q;
  assign grant_id_o  = gid_q;
  assign busy_o      = |pend;
endmodule

// File: tb/tb_multi_ctrl_fwd_arb.sv
// Bench for multi_ctrl_fwd_arb: directed beats, expected output beats queued
// at drive time and compared when the slot presents them; per-cycle checks
// of the one-hot ack. Build with MCFP_ARB_LOCK_EN to add the packet-lock case.
`timescale 1ns/1ps

module tb_multi_ctrl_fwd_arb;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 256;
  localparam int DEST_N  = 2;
  localparam int ID_W    = $clog2(NUM_REQ);

  typedef struct {
    logic [DEST_N-1:0] dest;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   gid;
  } exp_t;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DEST_N-1:0] req_dest;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [DEST_N-1:0]              b_valid_out;
  logic [DATA_W-1:0]              b_data_out;
  logic [DEST_N-1:0]              b_ready_in;
  logic [ID_W-1:0]                grant_id_o;
  logic                           busy_o;

  exp_t exp_q[$];
  exp_t mon_e;
  logic acc_prev = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  multi_ctrl_fwd_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEST_N(DEST_N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_dest_i  (req_dest),
    .req_data_i  (req_data),
`ifdef MCFP_ARB_LOCK_EN
    .req_last_i  (req_last),
`endif
    .req_ready_o (req_ready_o),
    .b_valid_out (b_valid_out),
    .b_data_out  (b_data_out),
    .b_ready_in  (b_ready_in),
    .grant_id_o  (grant_id_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int n);
    return {(DATA_W/32){32'hC0DE0000 ^ 32'(n)}};
  endfunction

  task automatic set_req(input int i, input logic v, input logic [DEST_N-1:0] d,
                         input logic [DATA_W-1:0] x, input logic last = 1'b1);
    req_valid[i] = v;
    req_dest[i]  = d;
    req_data[i]  = x;
    req_last[i]  = last;
  endtask

  task automatic push(input logic [DEST_N-1:0] d, input logic [DATA_W-1:0] x, input int g);
    exp_t e;
    e.dest = d;
    e.data = x;
    e.gid  = ID_W'(g);
    exp_q.push_back(e);
  endtask

  // Check the ack at mid-cycle, then advance to just after the next edge.
  task automatic step(input logic [NUM_REQ-1:0] exp_rdy, input string tag);
    @(negedge clk);
    chk(tag, req_ready_o, exp_rdy);
    @(posedge clk);
    #1;
  endtask

  // A beat accepted last cycle must now sit in the slot.
  always @(negedge clk) begin
    if (rst_n && acc_prev) begin
      chk("sb_has_beat", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("beat_valid", b_valid_out, mon_e.dest);
        if (mon_e.dest != '0) begin
          chk("beat_data", b_data_out, mon_e.data);
          chk("beat_gid", grant_id_o, mon_e.gid);
        end
      end
    end
    acc_prev <= rst_n && (|req_ready_o);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired nvec=%0d", nvec);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_dest   = '0;
    req_data   = '0;
    req_last   = '1;
    b_ready_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bvalid", b_valid_out, 0);
    chk("rst_bdata",  b_data_out, 0);
    chk("rst_gid",    grant_id_o, 0);
    chk("rst_busy",   busy_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All requesters valid: grants rotate 0,1,2,3,0,1.
    b_ready_in = '1;
    for (int r = 0; r < NUM_REQ; r++) set_req(r, 1'b1, 2'b11, pat(100 + r));
    for (int k = 0; k < 6; k++) begin
      int w;
      w = k % NUM_REQ;
      push(2'b11, req_data[w], w);
      step(4'b0001 << w, "t3_rr_ready");
      set_req(w, 1'b1, 2'b11, pat(200 + k));
    end
    for (int r = 0; r < NUM_REQ; r++) set_req(r, 1'b0, '0, '0);
    step(4'b0000, "t3_idle");

    // Back-to-back beats from req0, no bubbles (pointer now 2).
    for (int k = 1; k <= 3; k++) begin
      set_req(0, 1'b1, 2'b11, pat(k));
      push(2'b11, pat(k), 0);
      step(4'b0001, "t1_ready");
    end
    set_req(0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t1_ready_idle", req_ready_o, 0);
    chk("t1_busy", busy_o, 1);
    @(posedge clk);
    #1;

    // Split retire: req2 waits until the last pending bit goes.
    b_ready_in = 2'b00;
    set_req(1, 1'b1, 2'b11, pat(20));
    set_req(2, 1'b1, 2'b01, pat(21));
    push(2'b11, pat(20), 1);
    step(4'b0010, "t2_first");
    set_req(1, 1'b0, '0, '0);
    b_ready_in = 2'b01;
    step(4'b0000, "t2_partial");
    b_ready_in = 2'b10;
    push(2'b01, pat(21), 2);
    @(negedge clk);
    chk("t2_last_ready", req_ready_o, 4'b0100);
    chk("t2_pend10", b_valid_out, 2'b10);
    @(posedge clk);
    #1;
    set_req(2, 1'b0, '0, '0);
    b_ready_in = 2'b11;
    step(4'b0000, "t2_idle");

    // Zero mask: acked and dropped, slot contents kept, pointer moves to 3.
    set_req(2, 1'b1, 2'b00, pat(30));
    push(2'b00, pat(30), 2);
    step(4'b0100, "t4_zero_ready");
    set_req(2, 1'b0, '0, '0);
    @(negedge clk);
    chk("t4_no_valid", b_valid_out, 0);
    chk("t4_gid_kept", grant_id_o, 2);
    chk("t4_data_kept", b_data_out, pat(21));
    chk("t4_ready_idle", req_ready_o, 0);
    @(posedge clk);
    #1;
    set_req(0, 1'b1, 2'b01, pat(31));
    set_req(3, 1'b1, 2'b01, pat(32));
    push(2'b01, pat(32), 3);
    step(4'b1000, "t4_search3");
    set_req(3, 1'b0, '0, '0);
    push(2'b01, pat(31), 0);
    step(4'b0001, "t4_wrap");
    set_req(0, 1'b0, '0, '0);
    step(4'b0000, "t4_idle");

    // Stalled slot, reset mid-flight (pointer 1 -> req1 wins, pointer 2).
    b_ready_in = 2'b00;
    set_req(1, 1'b1, 2'b11, pat(40));
    set_req(3, 1'b1, 2'b11, pat(41));
    push(2'b11, pat(40), 1);
    step(4'b0010, "t6_acc");
    set_req(1, 1'b0, '0, '0);
    step(4'b0000, "t6_stall1");
    step(4'b0000, "t6_stall2");
    rst_n = 1'b0;
    #1;
    chk("t6_rst_bvalid", b_valid_out, 0);
    chk("t6_rst_gid", grant_id_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_data", b_data_out, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    b_ready_in = 2'b11;
    set_req(1, 1'b1, 2'b11, pat(42));
    push(2'b11, pat(42), 1);
    step(4'b0010, "t6_lowest");
    set_req(1, 1'b0, '0, '0);
    push(2'b11, pat(41), 3);
    step(4'b1000, "t6_next");
    set_req(3, 1'b0, '0, '0);
    step(4'b0000, "t6_idle");

`ifdef MCFP_ARB_LOCK_EN
    // Packet lock on req1 (pointer 0); req0 shut out until the last beat.
    set_req(1, 1'b1, 2'b01, pat(50), 1'b0);
    push(2'b01, pat(50), 1);
    step(4'b0010, "t5_b1");
    set_req(0, 1'b1, 2'b01, pat(60), 1'b1);
    set_req(1, 1'b1, 2'b01, pat(51), 1'b0);
    push(2'b01, pat(51), 1);
    step(4'b0010, "t5_b2");
    set_req(1, 1'b0, '0, '0, 1'b0);
    step(4'b0000, "t5_gap");
    set_req(1, 1'b1, 2'b01, pat(52), 1'b1);
    push(2'b01, pat(52), 1);
    step(4'b0010, "t5_b3");
    set_req(1, 1'b0, '0, '0);
    push(2'b01, pat(60), 0);
    step(4'b0001, "t5_release");
    set_req(0, 1'b0, '0, '0);
    step(4'b0000, "t5_idle");
`endif

    @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
